// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART receive and transmit blocks: the FSM state
//   encoding and the helper that turns clock frequency and line rate into a
//   per-bit clock count.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    localparam int DATA_BITS = 8;

    // Clock cycles per bit period.
    function automatic int baud_counter_max(input int clock_mhz, input int baud_rate);
        return (clock_mhz * 1_000_000) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
//   Two-flop synchroniser bringing an asynchronous pin into the clk domain.
//   Both flops reset to RESET_VAL so an idle line looks idle straight out of
//   reset.
// Ports
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   d_i    in  asynchronous input
//   q_o    out synchronised output (2 clk latency)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver (LSB first, one start bit, eight data bits, one stop
//   bit). Bits are sampled at mid-bit from the synchronised pin. A good frame
//   updates out_data with a one-cycle out_valid strobe; a low stop bit gives a
//   one-cycle out_frame_err strobe and leaves out_data untouched.
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   in_serial      in   serial pin (asynchronous, idles high)
//   out_data       out  last good byte, held until the next good frame
//   out_valid      out  one-cycle pulse, out_data updated this cycle
//   out_frame_err  out  one-cycle pulse, stop bit sampled low
//   out_is_active  out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int BaudRate       = 115200,
    parameter int ClockSpeed_MHz = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_serial,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_frame_err,
    output logic       out_is_active
);

    localparam int BAUD_COUNTER_MAX = baud_counter_max(ClockSpeed_MHz, BaudRate);
    localparam int HALF_BAUD        = BAUD_COUNTER_MAX / 2;
    localparam int CNT_W            = $clog2(BAUD_COUNTER_MAX);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BAUD - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_COUNTER_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic rx_s;

    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (in_serial),
        .q_o   (rx_s)
    );

    uart_state_e          state_q,    state_d;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [2:0]           bit_cnt_q,  bit_cnt_d;
    logic [7:0]           shift_q,    shift_d;
    logic [7:0]           data_q,     data_d;
    logic                 valid_q,    valid_d;
    logic                 err_q,      err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d    = ST_START;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end

            // Re-check the line at start mid-bit; a high line means the low
            // level was a glitch and the frame is dropped silently.
            ST_START: begin
                if (baud_cnt_q == HALF_LAST) begin
                    baud_cnt_d = '0;
                    state_d    = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_ONE;
                end
            end

            // Counting is already aligned to mid-bit, so each full bit period
            // lands on the next data mid-bit. LSB arrives first, so shift right.
            ST_DATA: begin
                if (baud_cnt_q == BIT_LAST) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_ONE;
                end
            end

            // Leaving at stop mid-bit lets IDLE catch a start edge that follows
            // the stop bit immediately.
            ST_STOP: begin
                if (baud_cnt_q == BIT_LAST) begin
                    baud_cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_ONE;
                end
            end

            // A line held low (break) reports one error, not one per frame time.
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_data      = data_q;
    assign out_valid     = valid_q;
    assign out_frame_err = err_q;
    assign out_is_active = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx. The receiver runs at 1 Mbaud on a 100 MHz
//   clock (100 clk per bit, half bit 50) so the whole sequence stays short.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_MHZ = 100;
    localparam int BAUD    = 1_000_000;
    localparam int BCM     = 100;          // clk per bit
    localparam int HALF    = 50;
    localparam int BIT_NS  = 1000;

    logic       clk;
    logic       rst_n;
    logic       in_serial;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_frame_err;
    logic       out_is_active;

    uart_rx #(
        .BaudRate       (BAUD),
        .ClockSpeed_MHz (CLK_MHZ)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_serial     (in_serial),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_frame_err (out_frame_err),
        .out_is_active (out_is_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: counts strobes and active cycles, sampled on the falling edge.
    int         cyc = 0;
    int         vcnt = 0;
    int         ecnt = 0;
    int         both_cnt = 0;
    int         act_cycles = 0;
    logic [7:0] vdat [0:63];
    int         vtim [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            vdat[vcnt[5:0]] = out_data;
            vtim[vcnt[5:0]] = cyc;
            vcnt = vcnt + 1;
        end
        if (out_frame_err) ecnt = ecnt + 1;
        if (out_valid && out_frame_err) both_cnt = both_cnt + 1;
        if (out_is_active) act_cycles = act_cycles + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int val, input int lo, input int hi);
        n_tests++;
        assert (val >= lo && val <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
        end
    endtask

    // Drives start, data and stop bits; the line is left at the stop level.
    task automatic send_bits(input logic [7:0] data, input logic stop, input int bit_ns);
        in_serial = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            in_serial = data[i];
            #(bit_ns);
        end
        in_serial = stop;
        #(bit_ns);
    endtask

    task automatic send_frame(input logic [7:0] data, input int bit_ns);
        send_bits(data, 1'b1, bit_ns);
        in_serial = 1'b1;
    endtask

    int v0, e0, a0;

    initial begin
        rst_n     = 1'b0;
        in_serial = 1'b1;
        #20;
        chk("reset_data",   {24'd0, out_data}, 32'h00);
        chk("reset_valid",  {31'd0, out_valid}, 32'd0);
        chk("reset_err",    {31'd0, out_frame_err}, 32'd0);
        chk("reset_active", {31'd0, out_is_active}, 32'd0);
        #20;
        rst_n = 1'b1;
        #(2 * BIT_NS);

        // 1: single frame 0xA5
        v0 = vcnt; e0 = ecnt; a0 = act_cycles;
        send_frame(8'hA5, BIT_NS);
        #(2 * BIT_NS);
        chk("t1_valid_count", vcnt - v0, 1);
        chk("t1_data", {24'd0, vdat[v0[5:0]]}, 32'hA5);
        chk("t1_err_count", ecnt - e0, 0);
        chk_rng("t1_active_cycles", act_cycles - a0, HALF + 9 * BCM - 1, HALF + 9 * BCM + 1);

        // 2: back-to-back 0x00, 0xFF, 0x55
        v0 = vcnt; e0 = ecnt;
        send_frame(8'h00, BIT_NS);
        send_frame(8'hFF, BIT_NS);
        send_frame(8'h55, BIT_NS);
        #(2 * BIT_NS);
        chk("t2_valid_count", vcnt - v0, 3);
        chk("t2_data0", {24'd0, vdat[v0[5:0]]}, 32'h00);
        chk("t2_data1", {24'd0, vdat[6'(v0 + 1)]}, 32'hFF);
        chk("t2_data2", {24'd0, vdat[6'(v0 + 2)]}, 32'h55);
        chk_rng("t2_gap01", vtim[6'(v0 + 1)] - vtim[v0[5:0]], 10 * BCM - 1, 10 * BCM + 1);
        chk_rng("t2_gap12", vtim[6'(v0 + 2)] - vtim[6'(v0 + 1)], 10 * BCM - 1, 10 * BCM + 1);
        chk("t2_err_count", ecnt - e0, 0);

        // 3: 200 ns glitch on the idle line
        v0 = vcnt; e0 = ecnt; a0 = act_cycles;
        in_serial = 1'b0;
        #200;
        in_serial = 1'b1;
        #(2 * BIT_NS);
        chk_rng("t3_active_cycles", act_cycles - a0, HALF - 1, HALF + 1);
        chk("t3_valid_count", vcnt - v0, 0);
        chk("t3_err_count", ecnt - e0, 0);
        chk("t3_idle", {31'd0, out_is_active}, 32'd0);

        // 4: bad stop bit, then a 20-bit break, then a good frame
        v0 = vcnt; e0 = ecnt;
        send_bits(8'h3C, 1'b0, BIT_NS);
        #(20 * BIT_NS);
        in_serial = 1'b1;
        #(2 * BIT_NS);
        chk("t4_err_count", ecnt - e0, 1);
        chk("t4_valid_count", vcnt - v0, 0);
        chk("t4_data_kept", {24'd0, out_data}, 32'h55);
        send_frame(8'h81, BIT_NS);
        #(2 * BIT_NS);
        chk("t4_valid_after", vcnt - v0, 1);
        chk("t4_data_after", {24'd0, out_data}, 32'h81);
        chk("t4_err_after", ecnt - e0, 1);

        // 5: reset during data bit 3 of 0x7E
        v0 = vcnt; e0 = ecnt;
        in_serial = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 3; i++) begin
            in_serial = (8'h7E >> i) & 8'h01;
            #(BIT_NS);
        end
        in_serial = 1'b1;            // bit 3 of 0x7E
        #(BIT_NS / 2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_data", {24'd0, out_data}, 32'h00);
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_err", {31'd0, out_frame_err}, 32'd0);
        chk("t5_rst_active", {31'd0, out_is_active}, 32'd0);
        #(2 * BIT_NS);
        rst_n = 1'b1;
        #(BIT_NS);
        chk("t5_no_pulse_valid", vcnt - v0, 0);
        chk("t5_no_pulse_err", ecnt - e0, 0);
        send_frame(8'h12, BIT_NS);
        #(2 * BIT_NS);
        chk("t5_valid_after", vcnt - v0, 1);
        chk("t5_data_after", {24'd0, out_data}, 32'h12);
        chk("t5_err_after", ecnt - e0, 0);

        // 6: 0xC3 at +3% and -3% line rate
        v0 = vcnt; e0 = ecnt;
        send_frame(8'hC3, (BIT_NS * 103) / 100);
        #(2 * BIT_NS);
        chk("t6_slow_valid", vcnt - v0, 1);
        chk("t6_slow_data", {24'd0, out_data}, 32'hC3);
        chk("t6_slow_err", ecnt - e0, 0);
        send_frame(8'hC3, (BIT_NS * 97) / 100);
        #(2 * BIT_NS);
        chk("t6_fast_valid", vcnt - v0, 2);
        chk("t6_fast_data", {24'd0, vdat[6'(v0 + 1)]}, 32'hC3);
        chk("t6_fast_err", ecnt - e0, 0);

        chk("never_valid_and_err", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
